// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// master = datapath side, slave = controller side.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RT_i;
  logic [4:0]       IFID_RS_i;
  logic [4:0]       IFID_RT_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             pc_write_o;
  logic             pc_branch_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_flush_o;
  logic             exmem_write_o;
  logic             memwb_write_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RT_i, IFID_RS_i, IFID_RT_i, branch_taken_i, mem_busy_i,
    input  pc_write_o, pc_branch_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_flush_o, exmem_write_o, memwb_write_o, timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RT_i, IFID_RS_i, IFID_RT_i, branch_taken_i, mem_busy_i,
    output pc_write_o, pc_branch_o, ifid_write_o, ifid_flush_o, idex_write_o,
           idex_flush_o, exmem_write_o, memwb_write_o, timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-stage write/flush controls for the 5-stage core,
// plus a memory-wait watchdog and saturating stall/flush event counters.
//   state   | meaning
//   ST_RUN  | data memory ready, wait counter idle
//   ST_WAIT | data memory busy, wait counter running toward timeout
module hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             stall_evt;
  logic             flush_evt;

  always_comb begin
    load_use = hz.IDEX_MemRead_i && (hz.IDEX_RT_i != 5'd0) &&
               ((hz.IDEX_RT_i == hz.IFID_RS_i) || (hz.IDEX_RT_i == hz.IFID_RT_i));
    // A busy cycle counts as a stall even when a branch is pending; the branch is replayed.
    stall_evt = hz.mem_busy_i || (!hz.branch_taken_i && load_use);
    flush_evt = !hz.mem_busy_i && hz.branch_taken_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      ST_RUN:  if (hz.mem_busy_i)  state_d = ST_WAIT;
      ST_WAIT: if (!hz.mem_busy_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (hz.mem_busy_i) begin
      if (state_q == ST_RUN)
        wait_cnt_d = 8'd1;
      else if (wait_cnt_q != 8'hFF)
        wait_cnt_d = wait_cnt_q + 8'd1;
      else
        wait_cnt_d = wait_cnt_q;
      if (wait_cnt_q == WAIT_LAST)
        timeout_d = 1'b1;
    end

    if (stall_evt && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_comb begin
    hz.pc_write_o    = 1'b0;
    hz.pc_branch_o   = 1'b0;
    hz.ifid_write_o  = 1'b0;
    hz.ifid_flush_o  = 1'b0;
    hz.idex_write_o  = 1'b0;
    hz.idex_flush_o  = 1'b0;
    hz.exmem_write_o = 1'b0;
    hz.memwb_write_o = 1'b0;

    if (!rst_i && !hz.mem_busy_i) begin
      hz.idex_write_o  = 1'b1;
      hz.exmem_write_o = 1'b1;
      hz.memwb_write_o = 1'b1;
      if (hz.branch_taken_i) begin
        hz.pc_write_o   = 1'b1;
        hz.pc_branch_o  = 1'b1;
        hz.ifid_write_o = 1'b1;
        hz.ifid_flush_o = 1'b1;
        hz.idex_flush_o = 1'b1;
      end else if (load_use) begin
        hz.idex_flush_o = 1'b1;
      end else begin
        hz.pc_write_o   = 1'b1;
        hz.ifid_write_o = 1'b1;
      end
    end
  end

  assign hz.timeout_o   = timeout_q;
  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (16-bit and 4-bit counters) share stimulus
// and are checked every cycle against an event-count model plus hand-computed literals.
module tb_hazard_ctrl;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread = 1'b0;
  logic [4:0] ex_rt = 5'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       br = 1'b0;
  logic       busy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // model state: plain event counts
  int m_stall = 0;
  int m_flush = 0;
  int m_busy_run = 0;
  bit m_to = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz_a ();
  hazard_ctrl_if #(.CNT_W(4))  hz_b ();

  assign hz_a.IDEX_MemRead_i = memread;
  assign hz_a.IDEX_RT_i      = ex_rt;
  assign hz_a.IFID_RS_i      = id_rs;
  assign hz_a.IFID_RT_i      = id_rt;
  assign hz_a.branch_taken_i = br;
  assign hz_a.mem_busy_i     = busy;
  assign hz_b.IDEX_MemRead_i = memread;
  assign hz_b.IDEX_RT_i      = ex_rt;
  assign hz_b.IFID_RS_i      = id_rs;
  assign hz_b.IFID_RT_i      = id_rt;
  assign hz_b.branch_taken_i = br;
  assign hz_b.mem_busy_i     = busy;

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(16)) u_dut_a (.clk_i(clk), .rst_i(rst), .hz(hz_a));
  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4))  u_dut_b (.clk_i(clk), .rst_i(rst), .hz(hz_b));

  // {pc_w, pc_br, ifid_w, ifid_fl, idex_w, idex_fl, exmem_w, memwb_w}
  wire [7:0] ctrl_a = {hz_a.pc_write_o, hz_a.pc_branch_o, hz_a.ifid_write_o, hz_a.ifid_flush_o,
                       hz_a.idex_write_o, hz_a.idex_flush_o, hz_a.exmem_write_o, hz_a.memwb_write_o};
  wire [7:0] ctrl_b = {hz_b.pc_write_o, hz_b.pc_branch_o, hz_b.ifid_write_o, hz_b.ifid_flush_o,
                       hz_b.idex_write_o, hz_b.idex_flush_o, hz_b.exmem_write_o, hz_b.memwb_write_o};

  localparam logic [7:0] C_RUN    = 8'b1010_1011;
  localparam logic [7:0] C_FLUSH  = 8'b1111_1111;
  localparam logic [7:0] C_STALL  = 8'b0000_1111;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard_now();
    return memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  function automatic logic [7:0] expected_ctrl();
    if (rst || busy)    return C_FREEZE;
    if (br)             return C_FLUSH;
    if (hazard_now())   return C_STALL;
    return C_RUN;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic compare_model();
    logic [7:0] e;
    e = expected_ctrl();
    check("ctrl_a", {24'd0, ctrl_a}, {24'd0, e});
    check("ctrl_b", {24'd0, ctrl_b}, {24'd0, e});
    check("stall_a", {16'd0, hz_a.stall_cnt_o}, sat(m_stall, 65535));
    check("stall_b", {28'd0, hz_b.stall_cnt_o}, sat(m_stall, 15));
    check("flush_a", {16'd0, hz_a.flush_cnt_o}, sat(m_flush, 65535));
    check("flush_b", {28'd0, hz_b.flush_cnt_o}, sat(m_flush, 15));
    check("timeout_a", {31'd0, hz_a.timeout_o}, {31'd0, m_to});
    check("timeout_b", {31'd0, hz_b.timeout_o}, {31'd0, m_to});
  endtask

  task automatic model_edge();
    if (busy || (!br && hazard_now())) m_stall++;
    if (!busy && br) m_flush++;
    if (busy) begin
      m_busy_run++;
      if (m_busy_run >= WAIT_MAX) m_to = 1'b1;
    end else begin
      m_busy_run = 0;
    end
  endtask

  task automatic model_reset();
    m_stall = 0;
    m_flush = 0;
    m_busy_run = 0;
    m_to = 1'b0;
  endtask

  // one clock: compare at falling edge, advance model at rising edge, return 1 time unit later
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic b, input logic bz);
    memread = mr; ex_rt = xrt; id_rs = rs; id_rt = rt; br = b; busy = bz;
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("run_after_reset", {24'd0, ctrl_a}, {24'd0, C_RUN});
    check("stall_after_reset", {16'd0, hz_a.stall_cnt_o}, 32'd0);
    tick();

    // load-use on rs, then on rt
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    check("loaduse_rs_ctrl", {24'd0, ctrl_a}, {24'd0, C_STALL});
    tick();
    check("loaduse_stall_cnt", {16'd0, hz_a.stall_cnt_o}, 32'd1);
    set_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0);
    tick();
    check("loaduse_rt_cnt", {16'd0, hz_a.stall_cnt_o}, 32'd2);

    // register zero never stalls; load to other reg never stalls
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("rt0_no_stall", {24'd0, ctrl_a}, {24'd0, C_RUN});
    tick();
    set_in(1'b1, 5'd9, 5'd8, 5'd8, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 5'd8, 5'd8, 5'd8, 1'b0, 1'b0);
    tick();
    check("no_extra_stall", {16'd0, hz_a.stall_cnt_o}, 32'd2);

    // branch together with load-use: flush wins
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
    check("branch_ctrl", {24'd0, ctrl_a}, {24'd0, C_FLUSH});
    tick();
    check("branch_flush_cnt", {16'd0, hz_a.flush_cnt_o}, 32'd1);
    check("branch_stall_same", {16'd0, hz_a.stall_cnt_o}, 32'd2);

    // busy with pending branch for 3 cycles, then the flush lands
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    check("busy_branch_freeze", {24'd0, ctrl_a}, {24'd0, C_FREEZE});
    repeat (3) tick();
    check("busy3_stall", {16'd0, hz_a.stall_cnt_o}, 32'd5);
    check("busy3_flush", {16'd0, hz_a.flush_cnt_o}, 32'd1);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("replayed_flush", {24'd0, ctrl_a}, {24'd0, C_FLUSH});
    tick();
    check("replayed_flush_cnt", {16'd0, hz_a.flush_cnt_o}, 32'd2);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();

    // watchdog: 14 busy edges clean, 15th trips, sticky after busy drops
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (14) tick();
    check("wd_14", {31'd0, hz_a.timeout_o}, 32'd0);
    tick();
    check("wd_15", {31'd0, hz_a.timeout_o}, 32'd1);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
    check("wd_sticky", {31'd0, hz_a.timeout_o}, 32'd1);
    check("stall_after_wd", {16'd0, hz_a.stall_cnt_o}, 32'd20);

    // 20 more stalls: 4-bit counter pinned at 15
    set_in(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0);
    repeat (20) tick();
    check("sat_b", {28'd0, hz_b.stall_cnt_o}, 32'd15);
    check("nosat_a", {16'd0, hz_a.stall_cnt_o}, 32'd40);

    // reset asserted mid-wait, between clock edges
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (4) tick();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_ctrl", {24'd0, ctrl_a}, {24'd0, C_FREEZE});
    check("async_rst_to", {31'd0, hz_a.timeout_o}, 32'd0);
    check("async_rst_stall", {16'd0, hz_a.stall_cnt_o}, 32'd0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("post_rst_run", {24'd0, ctrl_a}, {24'd0, C_RUN});
    tick();

    // watchdog restarts from zero after reset
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    repeat (14) tick();
    check("wd2_14", {31'd0, hz_a.timeout_o}, 32'd0);
    tick();
    check("wd2_15", {31'd0, hz_a.timeout_o}, 32'd1);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Produces per-stage write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Decision inputs: load-use hazard, taken branch resolved in EX, data-memory wait.
- Also keeps a memory-wait watchdog and saturating stall and flush event counters.

Parameters:
WAIT_MAX, 15, maximum consecutive mem_busy_i cycles before timeout_o sets (1..255)
CNT_W, 16, width of stall_cnt_o and flush_cnt_o

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RT_i  in  5  destination register of instruction in EX
IFID_RS_i  in  5  rs field of instruction in ID
IFID_RT_i  in  5  rt field of instruction in ID
branch_taken_i  in  1  branch in EX resolved taken
mem_busy_i  in  1  data memory not ready this cycle
pc_write_o  out  1  PC load enable
pc_branch_o  out  1  PC selects branch target
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clears to NOP
idex_write_o  out  1  ID/EX load enable
idex_flush_o  out  1  ID/EX loads all-zero control fields (bubble)
exmem_write_o  out  1  EX/MEM load enable
memwb_write_o  out  1  MEM/WB load enable
timeout_o  out  1  sticky watchdog error
stall_cnt_o  out  CNT_W  saturating count of stalled cycles
flush_cnt_o  out  CNT_W  saturating count of branch flushes

Behaviour:
- State machine: RUN and WAIT. Reset state is RUN. Registered state: FSM, wait counter (8 bit), timeout flag, two event counters.
- While rst_i is high:
  - all *_write_o = 0, all *_flush_o = 0, pc_branch_o = 0;
  - timeout_o = 0, both counters = 0, wait counter = 0.
- Control outputs are combinational from the current state and inputs (zero latency). They are decided by strict priority, highest first:
  1. mem_busy_i=1: freeze.
     - All five write enables 0, flushes 0, pc_branch_o 0.
     - branch_taken_i and load-use are ignored; the frozen EX stage presents them again after busy drops.
  2. branch_taken_i=1: flush.
     - pc_write_o=1, pc_branch_o=1, ifid_flush_o=1, idex_flush_o=1.
     - All write enables 1.
  3. Load-use stall:
     - Condition: IDEX_MemRead_i=1, IDEX_RT_i!=0, and (IDEX_RT_i==IFID_RS_i or IDEX_RT_i==IFID_RT_i).
     - pc_write_o=0, ifid_write_o=0, idex_flush_o=1; idex/exmem/memwb writes 1.
  4. Otherwise run: all write enables 1, flushes 0, pc_branch_o 0.
- Each flush asserts either ifid_flush_o or idex_flush_o only together with the matching write enable = 1.
- FSM transitions:
  - RUN→WAIT when mem_busy_i=1 at a clock edge.
  - WAIT→RUN when mem_busy_i=0 at an edge.
  - Outputs follow the priority above in both states; the state only drives the watchdog.
- Wait counter:
  - Cleared whenever mem_busy_i=0.
  - Increments each cycle mem_busy_i=1, saturating at 255.
  - When an edge sees mem_busy_i=1 with the counter equal to WAIT_MAX-1, timeout_o sets. Example: with WAIT_MAX=15, timeout_o is high after the 15th consecutive busy edge.
- timeout_o stays set until rst_i. It does not alter stall/flush behaviour.
- stall_cnt_o: +1 at each edge where priority 1 or 3 is active.
- flush_cnt_o: +1 at each edge where priority 2 is active.
- Both counters saturate at all-ones and never wrap.
- Simultaneous mem_busy_i and branch_taken_i: freeze wins and flush_cnt_o does not increment. The flush occurs on the first non-busy cycle.
- Simultaneous branch and load-use: flush wins. The instruction in ID is squashed, so no stall is needed.
- IDEX_RT_i=0 never causes a stall.
- rst_i asserted mid-WAIT: immediate return to RUN, outputs at reset values, watchdog cleared.

Test Plan:
- Reset: rst_i=1 mid-run with mem_busy_i=1 → all outputs 0 asynchronously. Release → run outputs (all writes 1), stall_cnt_o=0.
- Load-use: IDEX_MemRead_i=1, IDEX_RT_i=8, IFID_RS_i=8 for one cycle → pc_write_o=0, ifid_write_o=0, idex_flush_o=1, stall_cnt_o becomes 1. Repeat with IDEX_RT_i=0 → no stall.
- Branch flush: branch_taken_i=1 together with the load-use condition → pc_branch_o=1, ifid_flush_o=1, idex_flush_o=1, pc_write_o=1, flush_cnt_o=1, stall_cnt_o unchanged.
- Memory wait plus branch: mem_busy_i=1 for 3 cycles with branch_taken_i=1 → all writes 0 for 3 cycles, stall_cnt_o=3. Next cycle flush asserted, flush_cnt_o=1.
- Watchdog: WAIT_MAX=15:
  - mem_busy_i=1 for 14 cycles → timeout_o=0.
  - 15th edge → timeout_o=1.
  - Busy drops → timeout_o stays 1 until rst_i.
- Saturation: CNT_W=4, 20 consecutive stall cycles → stall_cnt_o=15, no wrap.
